// File: rtl/bram_arb_pkg.sv
// Shared types and helpers for the two-client block-RAM arbiter.
package bram_arb_pkg;

  // Number of requesters sharing the RAM; the arbiters are built for exactly two.
  localparam int NUM_CLIENTS = 2;

  // Default geometry of the shared RAM (word address width, word width).
  localparam int DEF_ADDR_WIDTH = 10;
  localparam int DEF_DATA_WIDTH = 32;

  // One bit is enough to name either client.
  typedef logic client_id_t;

  localparam client_id_t CLIENT_0 = 1'b0;
  localparam client_id_t CLIENT_1 = 1'b1;

  // The client that did not win; round-robin hands priority to it.
  function automatic client_id_t other_client(input client_id_t id);
    return ~id;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-request round-robin arbiter. The grant is combinational from the
// requests and the priority register; priority moves to the losing client
// only when the caller confirms the grant was used (en).
module rr_arbiter2
  import bram_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt,
  output client_id_t gnt_id,
  output logic       gnt_valid
);

  client_id_t prio_q;
  client_id_t prio_d;

  // Pick the winner and work out the priority for the next cycle.
  // NOTE: every output of a combinational block gets a default first so no
  // path through the if/else leaves a signal unassigned (that infers a latch).
  always_comb begin
    gnt       = 2'b00;
    gnt_id    = CLIENT_0;
    gnt_valid = |req;
    prio_d    = prio_q;

    if (req[0] && req[1]) begin
      gnt_id = prio_q;
    end else if (req[1]) begin
      gnt_id = CLIENT_1;
    end else begin
      gnt_id = CLIENT_0;
    end

    if (gnt_valid) begin
      gnt[gnt_id] = 1'b1;
      if (en) begin
        prio_d = other_client(gnt_id);
      end
    end
  end

  // Priority register; client 0 is favoured out of reset.
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q <= CLIENT_0;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule

// File: rtl/bram_dual_arbiter.sv
// Shares one simple-dual-port byte-enable block RAM between two clients.
// The write port and the read port are arbitrated independently, so one
// write and one read can go out per cycle. A read that targets the address
// being written in the same cycle is held off for a cycle, which also gives
// read-after-write ordering. Read data is parked per client until consumed.
module bram_dual_arbiter
  import bram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,  // multiple of 8
  parameter int BE_WIDTH   = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic                  req_valid_0,
  output logic                  req_ready_0,
  input  logic                  req_write_0,
  input  logic [ADDR_WIDTH-1:0] req_addr_0,
  input  logic [DATA_WIDTH-1:0] req_data_0,
  input  logic [BE_WIDTH-1:0]   req_be_0,
  output logic                  rsp_valid_0,
  input  logic                  rsp_ready_0,
  output logic [DATA_WIDTH-1:0] rsp_data_0,

  input  logic                  req_valid_1,
  output logic                  req_ready_1,
  input  logic                  req_write_1,
  input  logic [ADDR_WIDTH-1:0] req_addr_1,
  input  logic [DATA_WIDTH-1:0] req_data_1,
  input  logic [BE_WIDTH-1:0]   req_be_1,
  output logic                  rsp_valid_1,
  input  logic                  rsp_ready_1,
  output logic [DATA_WIDTH-1:0] rsp_data_1,

  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr,
  output logic                  ram_re,
  output logic                  ram_we,
  output logic [BE_WIDTH-1:0]   ram_be,
  output logic [DATA_WIDTH-1:0] ram_di,
  input  logic [DATA_WIDTH-1:0] ram_do
);

  // One client request, sized by this instance's RAM geometry.
  typedef struct packed {
    logic                  write;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic [BE_WIDTH-1:0]   be;
  } req_t;

  req_t [NUM_CLIENTS-1:0] req;
  logic [NUM_CLIENTS-1:0] req_valid;
  logic [NUM_CLIENTS-1:0] rsp_ready;
  logic [NUM_CLIENTS-1:0] req_ready;

  logic [NUM_CLIENTS-1:0] wr_cand;
  logic [NUM_CLIENTS-1:0] rd_cand;
  logic [NUM_CLIENTS-1:0] wr_gnt;
  logic [NUM_CLIENTS-1:0] rd_gnt;
  client_id_t             wr_id;
  client_id_t             rd_id;
  logic                   wr_any;
  logic                   rd_any;
  logic                   collision;
  logic                   rd_fire;
  logic [NUM_CLIENTS-1:0] rd_accept;

  // Read pipeline state: a read is in the RAM, or its data is parked.
  logic [NUM_CLIENTS-1:0]                 inflight_q;
  logic [NUM_CLIENTS-1:0]                 inflight_d;
  logic [NUM_CLIENTS-1:0]                 rsp_valid_q;
  logic [NUM_CLIENTS-1:0]                 rsp_valid_d;
  logic [NUM_CLIENTS-1:0][DATA_WIDTH-1:0] rsp_data_q;
  logic [NUM_CLIENTS-1:0][DATA_WIDTH-1:0] rsp_data_d;

  // Gather the flat per-client ports into indexable vectors.
  always_comb begin
    req_valid = {req_valid_1, req_valid_0};
    rsp_ready = {rsp_ready_1, rsp_ready_0};
    req[0]    = '{write: req_write_0, addr: req_addr_0, data: req_data_0, be: req_be_0};
    req[1]    = '{write: req_write_1, addr: req_addr_1, data: req_data_1, be: req_be_1};
  end

  // Who may compete for each port. A client reads only when nothing of its
  // own is in the RAM and its parked slot is free or being emptied now.
  always_comb begin
    wr_cand = '0;
    rd_cand = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      wr_cand[i] = req_valid[i] && req[i].write;
      rd_cand[i] = req_valid[i] && !req[i].write && !inflight_q[i] &&
                   (!rsp_valid_q[i] || rsp_ready[i]);
    end
  end

  rr_arbiter2 u_wr_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (wr_cand),
    .en        (1'b1),
    .gnt       (wr_gnt),
    .gnt_id    (wr_id),
    .gnt_valid (wr_any)
  );

  // A read withdrawn for a collision keeps its priority for the retry.
  rr_arbiter2 u_rd_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (rd_cand),
    .en        (!collision),
    .gnt       (rd_gnt),
    .gnt_id    (rd_id),
    .gnt_valid (rd_any)
  );

  // Resolve read/write collisions and drive the RAM ports and handshakes.
  // Nothing is accepted or issued while reset is asserted.
  always_comb begin
    collision   = wr_any && rd_any && (req[rd_id].addr == req[wr_id].addr);
    rd_fire     = rd_any && !collision;
    rd_accept   = rd_fire ? rd_gnt : '0;
    req_ready   = rst_n ? (wr_gnt | rd_accept) : '0;

    ram_we      = rst_n && wr_any;
    ram_wr_addr = req[wr_id].addr;
    ram_di      = req[wr_id].data;
    ram_be      = req[wr_id].be;

    ram_re      = rst_n && rd_fire;
    ram_rd_addr = req[rd_id].addr;
  end

  // Next state of the read pipeline. RAM data lands one cycle after the
  // read was issued; a capture takes precedence over a pop of older data.
  always_comb begin
    inflight_d  = rd_accept;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (inflight_q[i]) begin
        rsp_valid_d[i] = 1'b1;
        rsp_data_d[i]  = ram_do;
      end else if (rsp_ready[i]) begin
        rsp_valid_d[i] = 1'b0;
      end
    end
  end

  // Read pipeline registers. Reset discards anything in flight.
  // NOTE: the small response holding registers are reset to zero, but the
  // RAM array itself lives outside and is never cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q  <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      inflight_q  <= inflight_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign req_ready_0 = req_ready[0];
  assign req_ready_1 = req_ready[1];
  assign rsp_valid_0 = rsp_valid_q[0];
  assign rsp_valid_1 = rsp_valid_q[1];
  assign rsp_data_0  = rsp_data_q[0];
  assign rsp_data_1  = rsp_data_q[1];

endmodule

// File: tb/tb_bram_dual_arbiter.sv
// Self-checking bench for bram_dual_arbiter: a behavioural RAM, a
// transaction-level reference model compared every cycle, directed
// scenarios with literal expectations, then randomized traffic.
module tb_bram_dual_arbiter;

  localparam int AW    = 10;
  localparam int DW    = 32;
  localparam int BW    = DW / 8;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic [1:0]         v, w, rr;
  logic [1:0][AW-1:0] a;
  logic [1:0][DW-1:0] d;
  logic [1:0][BW-1:0] be;

  logic          req_ready_0, req_ready_1, rsp_valid_0, rsp_valid_1;
  logic [DW-1:0] rsp_data_0, rsp_data_1;
  logic [AW-1:0] ram_rd_addr, ram_wr_addr;
  logic          ram_re, ram_we;
  logic [BW-1:0] ram_be;
  logic [DW-1:0] ram_di, ram_do;

  always #5 clk = ~clk;

  bram_dual_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_0(v[0]), .req_ready_0(req_ready_0), .req_write_0(w[0]),
    .req_addr_0(a[0]), .req_data_0(d[0]), .req_be_0(be[0]),
    .rsp_valid_0(rsp_valid_0), .rsp_ready_0(rr[0]), .rsp_data_0(rsp_data_0),
    .req_valid_1(v[1]), .req_ready_1(req_ready_1), .req_write_1(w[1]),
    .req_addr_1(a[1]), .req_data_1(d[1]), .req_be_1(be[1]),
    .rsp_valid_1(rsp_valid_1), .rsp_ready_1(rr[1]), .rsp_data_1(rsp_data_1),
    .ram_rd_addr(ram_rd_addr), .ram_wr_addr(ram_wr_addr),
    .ram_re(ram_re), .ram_we(ram_we), .ram_be(ram_be), .ram_di(ram_di),
    .ram_do(ram_do)
  );

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w,
                                          input logic [DW-1:0] new_w,
                                          input logic [BW-1:0] en);
    logic [DW-1:0] r;
    r = old_w;
    for (int b = 0; b < BW; b++) if (en[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  // Behavioural block RAM: registered read, undefined on same-address R+W.
  logic [DW-1:0] ram [DEPTH];
  always @(posedge clk) begin
    if (ram_re) ram_do <= (ram_we && ram_rd_addr == ram_wr_addr) ? 'x : ram[ram_rd_addr];
    if (ram_we) ram[ram_wr_addr] <= merge(ram[ram_wr_addr], ram_di, ram_be);
  end

  // Reference model state.
  logic [DW-1:0] mem_ref [DEPTH];
  int            cyc;
  int            m_wr_prio, m_rd_prio;
  bit            m_pend [2];
  int            m_land [2];
  logic [DW-1:0] m_pdata [2];
  bit            m_hold [2];
  logic [DW-1:0] m_hdata [2];
  bit            acc [2];
  bit            acc_dut [2];
  int            dut_rd_order [$];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One cycle of the reference: predict outputs, compare, then advance.
  task automatic model_cycle();
    int wc, rc;
    bit elig [2];
    bit exp_rdy [2];
    bit rdy [2];
    bit collide, re_exp;
    rdy[0] = req_ready_0;
    rdy[1] = req_ready_1;
    if (!rst_n) begin
      check("rst_req_ready_0", 64'(req_ready_0), 64'(0));
      check("rst_req_ready_1", 64'(req_ready_1), 64'(0));
      check("rst_ram_re", 64'(ram_re), 64'(0));
      check("rst_ram_we", 64'(ram_we), 64'(0));
      check("rst_rsp_valid_0", 64'(rsp_valid_0), 64'(0));
      check("rst_rsp_valid_1", 64'(rsp_valid_1), 64'(0));
      check("rst_rsp_data_0", 64'(rsp_data_0), 64'(0));
      check("rst_rsp_data_1", 64'(rsp_data_1), 64'(0));
      m_wr_prio = 0;
      m_rd_prio = 0;
      for (int i = 0; i < 2; i++) begin
        m_pend[i] = 0; m_hold[i] = 0; m_hdata[i] = '0; acc[i] = 0; acc_dut[i] = 0;
      end
      cyc++;
      return;
    end

    wc = -1;
    if (v[0] && w[0] && v[1] && w[1]) wc = m_wr_prio;
    else if (v[0] && w[0]) wc = 0;
    else if (v[1] && w[1]) wc = 1;

    for (int i = 0; i < 2; i++)
      elig[i] = v[i] && !w[i] && !m_pend[i] && (!m_hold[i] || rr[i]);
    rc = -1;
    if (elig[0] && elig[1]) rc = m_rd_prio;
    else if (elig[0]) rc = 0;
    else if (elig[1]) rc = 1;

    collide = (wc >= 0) && (rc >= 0) && (a[wc] == a[rc]);
    re_exp  = (rc >= 0) && !collide;
    for (int i = 0; i < 2; i++) exp_rdy[i] = (wc == i) || (re_exp && rc == i);

    check("req_ready_0", 64'(req_ready_0), 64'(exp_rdy[0]));
    check("req_ready_1", 64'(req_ready_1), 64'(exp_rdy[1]));
    check("ram_we", 64'(ram_we), 64'(wc >= 0));
    if (wc >= 0) begin
      check("ram_wr_addr", 64'(ram_wr_addr), 64'(a[wc]));
      check("ram_di", 64'(ram_di), 64'(d[wc]));
      check("ram_be", 64'(ram_be), 64'(be[wc]));
    end
    check("ram_re", 64'(ram_re), 64'(re_exp));
    if (re_exp) check("ram_rd_addr", 64'(ram_rd_addr), 64'(a[rc]));
    if (ram_re && ram_we) check("no_same_addr_rw", 64'(ram_rd_addr != ram_wr_addr), 64'(1));
    check("rsp_valid_0", 64'(rsp_valid_0), 64'(m_hold[0]));
    check("rsp_valid_1", 64'(rsp_valid_1), 64'(m_hold[1]));
    check("rsp_data_0", 64'(rsp_data_0), 64'(m_hdata[0]));
    check("rsp_data_1", 64'(rsp_data_1), 64'(m_hdata[1]));

    for (int i = 0; i < 2; i++) begin
      acc[i]     = exp_rdy[i];
      acc_dut[i] = v[i] && rdy[i];
      if (acc_dut[i] && !w[i]) dut_rd_order.push_back(i);
    end

    for (int i = 0; i < 2; i++) begin
      if (m_pend[i] && m_land[i] == cyc) begin
        m_hold[i] = 1; m_hdata[i] = m_pdata[i]; m_pend[i] = 0;
      end else if (m_hold[i] && rr[i]) begin
        m_hold[i] = 0;
      end
    end
    if (re_exp) begin
      m_pend[rc]  = 1;
      m_land[rc]  = cyc + 1;
      m_pdata[rc] = mem_ref[a[rc]];
      m_rd_prio   = 1 - rc;
    end
    if (wc >= 0) begin
      mem_ref[a[wc]] = merge(mem_ref[a[wc]], d[wc], be[wc]);
      m_wr_prio      = 1 - wc;
    end
    cyc++;
  endtask

  always @(negedge clk) model_cycle();

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request and hold it until the model says it was taken.
  task automatic do_req(input int i, input bit wr, input logic [AW-1:0] ad,
                        input logic [DW-1:0] dat, input logic [BW-1:0] b,
                        input string name);
    v[i] = 1'b1; w[i] = wr; a[i] = ad; d[i] = dat; be[i] = b;
    for (int k = 0; k < 50; k++) begin
      step();
      if (acc[i]) begin
        v[i] = 1'b0;
        return;
      end
    end
    check({name, "_timeout"}, 64'(0), 64'(1));
    v[i] = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      ram[i] = '0;
      mem_ref[i] = '0;
    end
    v = '0; w = '0; a = '0; d = '0; be = '0; rr = 2'b11;
    cyc = 0;

    // Reset with requests pending: nothing may be accepted or issued.
    v = 2'b11; w = 2'b01; a[0] = AW'(3); a[1] = AW'(4); be[0] = BW'(15);
    step();
    step();
    check("rst_ready0_literal", 64'(req_ready_0), 64'(0));
    check("rst_re_literal", 64'(ram_re), 64'(0));
    v = '0; w = '0;
    rst_n = 1'b1;
    step();

    // Full write then read from the other client; 2-cycle latency.
    do_req(0, 1, AW'('h010), 32'hDEADBEEF, BW'('hF), "t1_wr");
    do_req(1, 0, AW'('h010), '0, '0, "t1_rd");
    check("t1_not_yet_valid", 64'(rsp_valid_1), 64'(0));
    step();
    check("t1_valid", 64'(rsp_valid_1), 64'(1));
    check("t1_data", 64'(rsp_data_1), 64'(32'hDEADBEEF));

    // Partial write (low two bytes) then read back.
    do_req(0, 1, AW'('h010), 32'h11223344, BW'('h3), "t2_wr");
    do_req(0, 0, AW'('h010), '0, '0, "t2_rd");
    step();
    check("t2_valid", 64'(rsp_valid_0), 64'(1));
    check("t2_data", 64'(rsp_data_0), 64'(32'hDEAD3344));

    // Fresh priority, preload, then both clients read back to back.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    for (int k = 0; k < 8; k++)
      do_req(k % 2, 1, AW'('h100 + k), 32'hC0DE0000 + 32'(k), BW'('hF), "t3_pre");
    dut_rd_order.delete();
    fork
      begin
        for (int k = 0; k < 4; k++) do_req(0, 0, AW'('h100 + 2 * k), '0, '0, "t3_rd0");
      end
      begin
        for (int k = 0; k < 4; k++) do_req(1, 0, AW'('h101 + 2 * k), '0, '0, "t3_rd1");
      end
    join
    step();
    step();
    step();
    for (int k = 0; k < 4; k++)
      check("t3_grant_order", 64'(dut_rd_order.size() > k ? dut_rd_order[k] : 99), 64'(k % 2));

    // Same-address write and read in one cycle: write wins, read retries.
    v = 2'b11; w = 2'b01;
    a[0] = AW'('h005); d[0] = 32'hAAAAAAAA; be[0] = BW'('hF);
    a[1] = AW'('h005);
    step();
    check("t4_wr_accepted", 64'(acc_dut[0]), 64'(1));
    check("t4_rd_blocked", 64'(acc_dut[1]), 64'(0));
    v[0] = 1'b0;
    step();
    check("t4_rd_retried", 64'(acc_dut[1]), 64'(1));
    v[1] = 1'b0;
    step();
    check("t4_valid", 64'(rsp_valid_1), 64'(1));
    check("t4_data", 64'(rsp_data_1), 64'(32'hAAAAAAAA));

    // Back-pressure: data held, next read blocked until rsp_ready rises.
    rr[0] = 1'b0;
    do_req(0, 0, AW'('h005), '0, '0, "t5_rd");
    v[0] = 1'b1; w[0] = 1'b0; a[0] = AW'('h100);
    step();
    for (int k = 0; k < 5; k++) begin
      check("t5_valid_held", 64'(rsp_valid_0), 64'(1));
      check("t5_data_held", 64'(rsp_data_0), 64'(32'hAAAAAAAA));
      check("t5_read_blocked", 64'(acc_dut[0]), 64'(0));
      step();
    end
    check("t5_read_blocked_last", 64'(acc_dut[0]), 64'(0));
    rr[0] = 1'b1;
    step();
    check("t5_accept_on_ready", 64'(acc_dut[0]), 64'(1));
    v[0] = 1'b0;
    step();
    check("t5_new_data", 64'(rsp_data_0), 64'(32'hC0DE0000));

    // Reset one cycle after a read handshake: the response is discarded.
    do_req(1, 0, AW'('h010), '0, '0, "t6_rd");
    rst_n = 1'b0;
    v = 2'b11; w = 2'b11;
    a[0] = AW'('h020); d[0] = 32'h0000_0A0A; be[0] = BW'('hF);
    a[1] = AW'('h021); d[1] = 32'h0000_0B0B; be[1] = BW'('hF);
    for (int k = 0; k < 3; k++) begin
      step();
      check("t6_rst_we", 64'(ram_we), 64'(0));
      check("t6_rst_re", 64'(ram_re), 64'(0));
      check("t6_rst_ready1", 64'(req_ready_1), 64'(0));
    end
    rst_n = 1'b1;
    step();
    check("t6_first_grant_c0", 64'(acc_dut[0]), 64'(1));
    check("t6_first_loser_c1", 64'(acc_dut[1]), 64'(0));
    v[0] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("t6_no_stale_rsp", 64'(rsp_valid_1), 64'(0));
      if (acc[1]) v[1] = 1'b0;
      step();
    end
    v = '0;
    step();

    // Randomized traffic over a small address window to force collisions.
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 2; i++) begin
        if (v[i] && acc[i]) v[i] = 1'b0;
        if (!v[i] && $urandom_range(0, 2) != 0) begin
          v[i]  = 1'b1;
          w[i]  = ($urandom_range(0, 2) == 0);
          a[i]  = AW'($urandom_range(0, 15));
          d[i]  = $urandom;
          be[i] = BW'($urandom_range(0, 15));
        end
        rr[i] = ($urandom_range(0, 3) != 0);
      end
      step();
    end
    v = '0;
    rr = 2'b11;
    repeat (5) step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/bram_dual_arbiter.md
Name: bram_dual_arbiter

Overview:
- Shares one dual-port byte-enable block RAM (separate read/write ports, 1-cycle registered read, undefined output on same-address read+write) between two requesters, e.g. fetch and load/store.
- Arbitrates the write port and the read port independently with round-robin, so one read and one write can proceed per cycle.
- Never issues a same-address read and write in the same cycle.
- Buffers read data per client so back-pressure never loses data.

Parameters:
- ADDR_WIDTH, 10, word address width of the RAM.
- DATA_WIDTH, 32, word width; must be a multiple of 8.
- BE_WIDTH, DATA_WIDTH/8, byte-enable width.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST_N  in  1  asynchronous active-low reset.
- REQ_VALID_0/1  in  1  request valid, client 0/1.
- REQ_READY_0/1  out  1  request accepted this cycle.
- REQ_WRITE_0/1  in  1  1 = write, 0 = read.
- REQ_ADDR_0/1  in  ADDR_WIDTH  word address.
- REQ_DATA_0/1  in  DATA_WIDTH  write data.
- REQ_BE_0/1  in  BE_WIDTH  write byte enables.
- RSP_VALID_0/1  out  1  read data valid.
- RSP_READY_0/1  in  1  client consumes read data.
- RSP_DATA_0/1  out  DATA_WIDTH  read data.
- RAM_RD_ADDR  out  ADDR_WIDTH  RAM read address.
- RAM_WR_ADDR  out  ADDR_WIDTH  RAM write address.
- RAM_RE  out  1  RAM read enable.
- RAM_WE  out  1  RAM write enable.
- RAM_BE  out  BE_WIDTH  RAM byte enables.
- RAM_DI  out  DATA_WIDTH  RAM write data.
- RAM_DO  in  DATA_WIDTH  RAM read data, valid the cycle after RAM_RE.

Behaviour:
- Reset values: RSP_VALID_0/1 = 0, rsp data registers = 0, inflight flags = 0, wr_prio = rd_prio = client 0.
- While RST_N is low: RAM_RE = RAM_WE = 0, REQ_READY_0/1 = 0.
- Handshake: a request completes when REQ_VALID && REQ_READY. REQ_READY is combinational from state and the current requests. Request fields must be held stable while VALID && !READY.
- Write arbitration: candidates are clients with VALID && WRITE. With two candidates, grant wr_prio. On any grant, wr_prio becomes the non-granted client. Granted write drives RAM_WE = 1, RAM_WR_ADDR, RAM_DI, RAM_BE.
- BE = 0 write: still accepted, RAM_WE still asserted, memory unchanged.
- Read eligibility: VALID && !WRITE && !inflight_i && (!RSP_VALID_i || RSP_READY_i).
- Read arbitration: round-robin among eligible clients using rd_prio, updated the same way as wr_prio. Granted read drives RAM_RE = 1, RAM_RD_ADDR.
- Collision: if the granted read address equals the granted write address, the read grant is withdrawn (its REQ_READY = 0, RAM_RE = 0). rd_prio is unchanged. The read is retried next cycle.
- Read pipeline:
  - Accept at cycle t sets inflight_i.
  - At the end of cycle t+1, RAM_DO is captured into the rsp register, RSP_VALID_i is set and inflight_i is cleared.
  - Latency from read handshake to RSP_VALID is 2 cycles.
  - Per-client read throughput is 1 per 2 cycles.
- RSP_DATA is held until RSP_READY. Pop and capture in the same cycle leaves RSP_VALID = 1 with the new data.
- Read-after-write ordering: a write accepted at cycle t is visible to any read accepted at cycle t+1 or later.
- Each client issues at most one request per cycle.
- Reset mid-operation: inflight reads are discarded, no response after release, RAM contents untouched.

Decomposition:
- Package bram_arb_pkg:
  - NUM_CLIENTS = 2.
  - Typedef client_id_t.
  - Parameterised request struct {write, addr, data, be}.
- Sub-module rr_arbiter2: two-request round-robin arbiter with priority register, grant enable and async reset. Instantiated once for writes and once for reads.

Test Plan:
- Reset; client0 writes addr 0x010 data 0xDEADBEEF BE 0xF; client1 reads 0x010 -> RSP_VALID_1 two cycles after the read handshake, RSP_DATA_1 = 0xDEADBEEF.
- Client0 writes 0x11223344 BE 0x3 to 0x010, then reads 0x010 -> 0xDEAD3344.
- Both clients assert reads to distinct addresses every cycle with RSP_READY high -> grants alternate 0,1,0,1 starting with client 0; each client receives data in request order.
- Same cycle: client0 writes 0xAAAAAAAA to 0x005, client1 reads 0x005 -> write accepted, REQ_READY_1 = 0, read accepted next cycle returns 0xAAAAAAAA. A monitor must never see RAM_RE && RAM_WE with equal addresses.
- RSP_READY_0 held low for 5 cycles after a read -> RSP_DATA_0 stable; the next client0 read is not accepted until the cycle RSP_READY_0 rises.
- Drop RST_N one cycle after a client1 read handshake; release -> no RSP_VALID_1, RAM_RE/RAM_WE low during reset, first contested grant goes to client 0.
